node_weight_gen: RTL and testbench
==================================

# node_weight_gen

Computes the per-node PageRank out-link weight vector from an N×N adjacency matrix. For each node j it produces weight = 1/outdeg(j) in unsigned Q0.WIDTH, where outdeg(j) counts column j. It sits directly upstream of the `ant` PageRank engine, and its `nodeWeight` bus connects straight to that engine's `nodeWeight` input. Division is done sequentially, one quotient bit per cycle, using a single shared restoring divider.

## Interface
- `N`, default 4: number of nodes.
- `WIDTH`, default 16: weight width, unsigned Q0.WIDTH.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `start` input, 1 bit: request a computation; sampled only in IDLE.
- `adj` input, N*N bits: adjacency matrix. Bit `adj[i*N+j]` = 1 means node j links to node i.
- `busy` output, 1 bit: high from the cycle after `start` is accepted through the DONE cycle.
- `done` output, 1 bit: one-cycle pulse when a new result is committed.
- `valid` output, 1 bit: set on the first `done` after reset; cleared only by reset.
- `nodeWeight` output, N*WIDTH bits: slice `[(j+1)*WIDTH-1 : j*WIDTH]` is the weight of node j.
- `dangling` output, N bits: bit j = 1 when outdeg(j) = 0.

## Operation
- States: IDLE, COUNT, DIV, WRITE, DONE.
- IDLE:
  - If `start`=1, latch `adj` into an internal copy, set j=0, go to COUNT.
  - `adj` changes outside this acceptance edge have no effect.
- COUNT (1 cycle):
  - deg = popcount of latched `adj[i*N+j]` over i = 0..N-1. deg register width is clog2(N+1).
  - Load dividend = 2^WIDTH (WIDTH+1 bits), clear the remainder, go to DIV.
- DIV (exactly WIDTH+1 cycles):
  - Restoring division, MSB first, one quotient bit per cycle.
  - Runs for every deg value, including 0 and 1, so latency is data-independent.
- WRITE (1 cycle): write the shadow slice j, then:
  - deg = 0: weight 0, shadow dangling bit = 1.
  - deg = 1: the quotient 2^WIDTH saturates to 2^WIDTH−1 (0xFFFF for WIDTH=16).
  - Otherwise: weight = floor(2^WIDTH / deg), with the low WIDTH bits exact.
  - If j = N−1 go to DONE; else j++ and go to COUNT.
- DONE (1 cycle):
  - Copy the shadow weights and shadow dangling bits to `nodeWeight` and `dangling` in the same edge.
  - Pulse `done`, set `valid`, return to IDLE.
- Output stability: `nodeWeight` and `dangling` change only on the DONE edge, so a downstream consumer never sees a partial vector.
- `start` during COUNT, DIV, WRITE or DONE is ignored. It is not queued.
- Reset mid-operation: return to IDLE; `busy`, `done` and `valid` = 0; `nodeWeight` = 0; `dangling` = 0; shadow registers and j cleared. The aborted result is never committed.

## Timing
- Reset values: `busy`=0, `done`=0, `valid`=0, `nodeWeight`=0, `dangling`=0; state IDLE.
- Let edge 0 be the edge where `start` is accepted.
  - `busy`=1 from the cycle after edge 0.
  - Each node occupies WIDTH+3 cycles: COUNT 1, DIV WIDTH+1, WRITE 1.
  - DONE cycle, with `done`=1, is cycle 1 + N*(WIDTH+3) after edge 0. This is cycle 77 for N=4, WIDTH=16.
  - `busy` drops with the return to IDLE, one cycle after DONE.
- Back-to-back: a `start` held high through DONE is accepted on the following IDLE edge. The minimum start-to-start spacing is 2 + N*(WIDTH+3) cycles.
- The design is fully synchronous apart from the reset assertion, which clears state without waiting for a clock edge.

## Test plan
- **Nominal matrix.** Rows 0011 / 1000 / 1101 / 1100, i.e. `adj[15:0]` = 16'b0011_1011_0001_1100, then pulse `start`. Required: `nodeWeight` = {8000, FFFF, 8000, 5555} (node3..node0), `dangling`=0000, `done` exactly at cycle 77, `valid`=1 afterwards.
- **Degree extremes.** `adj` = all ones → every weight is 4000. `adj` = all zeros → every weight is 0000 and `dangling`=1111. Each takes the same 77-cycle latency.
- **Input and start masking.** Start the nominal matrix, then at cycle 20 set `adj` to all ones and pulse `start` again. Required: the nominal result at cycle 77 and no second `done`.
- **Reset mid-run.** Assert `reset`=0 at cycle 30 of a run that follows a completed all-ones run. Required: `busy`, `valid`, `nodeWeight` and `dangling` all go to 0 immediately. After release, a fresh nominal run completes correctly.
- **Back-to-back.** Hold `start`=1 continuously, switching `adj` after the first acceptance. Required: the second acceptance occurs on the cycle after the first `done`. The second result reflects the `adj` value present at that edge, and `nodeWeight` holds the first result until the second `done`.

Source files
------------

// File: rtl/node_weight_gen_if.sv
// Handshake and result bus between the adjacency source, node_weight_gen and the
// PageRank engine that consumes nodeWeight.
interface node_weight_gen_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16
);
  logic                 start;
  logic [N*N-1:0]       adj;
  logic                 busy;
  logic                 done;
  logic                 valid;
  logic [N*WIDTH-1:0]   nodeWeight;
  logic [N-1:0]         dangling;

  modport master (
    output start, adj,
    input  busy, done, valid, nodeWeight, dangling
  );

  modport slave (
    input  start, adj,
    output busy, done, valid, nodeWeight, dangling
  );
endinterface

// File: rtl/node_weight_gen.sv
// Per-node out-link weight 1/outdeg(j) in unsigned Q0.WIDTH, computed node by node
// with one shared restoring divider; results are committed as a whole vector.
//
// state   | meaning
// IDLE    | waiting for start; adj is latched on the accepting edge
// COUNT   | popcount of column j into deg, divider operands loaded
// DIV     | WIDTH+1 restoring-division steps of 2^WIDTH / deg
// WRITE   | weight of node j written to the shadow vector
// DONE    | shadow vector copied to the outputs, done pulsed
module node_weight_gen #(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  node_weight_gen_if.slave bus
);

  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(N + 1);
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DIV   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [N*N-1:0]     adj_q, adj_d;
  logic [JW-1:0]      j_q, j_d;
  logic [DW-1:0]      deg_q, deg_d;
  logic [DW-1:0]      rem_q, rem_d;
  logic [WIDTH:0]     dvd_q, dvd_d;
  logic [WIDTH:0]     quo_q, quo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N*WIDTH-1:0] sh_w_q, sh_w_d;
  logic [N-1:0]       sh_dang_q, sh_dang_d;
  logic [N*WIDTH-1:0] nw_q, nw_d;
  logic [N-1:0]       dang_q, dang_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;

  logic [DW-1:0]      pop;
  logic [DW:0]        rem_sh;
  logic [DW-1:0]      rem_diff;
  logic [WIDTH-1:0]   weight;

  always_comb begin
    state_d   = state_q;
    adj_d     = adj_q;
    j_d       = j_q;
    deg_d     = deg_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    sh_w_d    = sh_w_q;
    sh_dang_d = sh_dang_q;
    nw_d      = nw_q;
    dang_d    = dang_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;

    pop = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (JW'(k) == j_q && adj_q[i*N+k]) pop = pop + DW'(1);
      end
    end

    rem_sh   = {rem_q, dvd_q[WIDTH]};
    rem_diff = rem_sh[DW-1:0] - deg_q;

    // deg=1 yields exactly 2^WIDTH, the only quotient with the top bit set
    if (deg_q == '0)      weight = '0;
    else if (quo_q[WIDTH]) weight = '1;
    else                  weight = quo_q[WIDTH-1:0];

    case (state_q)
      S_IDLE: begin
        busy_d = bus.start;
        if (bus.start) begin
          adj_d   = bus.adj;
          j_d     = '0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        deg_d   = pop;
        dvd_d   = {1'b1, {WIDTH{1'b0}}};
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = CW'(WIDTH);
        state_d = S_DIV;
      end
      S_DIV: begin
        dvd_d = {dvd_q[WIDTH-1:0], 1'b0};
        if (rem_sh >= {1'b0, deg_q}) begin
          rem_d = rem_diff;
          quo_d = {quo_q[WIDTH-1:0], 1'b1};
        end else begin
          rem_d = rem_sh[DW-1:0];
          quo_d = {quo_q[WIDTH-1:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_WRITE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_WRITE: begin
        for (int k = 0; k < N; k++) begin
          if (JW'(k) == j_q) begin
            sh_w_d[k*WIDTH +: WIDTH] = weight;
            sh_dang_d[k]             = (deg_q == '0);
          end
        end
        if (j_q == JW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + JW'(1);
          state_d = S_COUNT;
        end
      end
      S_DONE: begin
        nw_d    = sh_w_q;
        dang_d  = sh_dang_q;
        done_d  = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      adj_q     <= '0;
      j_q       <= '0;
      deg_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      sh_w_q    <= '0;
      sh_dang_q <= '0;
      nw_q      <= '0;
      dang_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      adj_q     <= adj_d;
      j_q       <= j_d;
      deg_q     <= deg_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      sh_w_q    <= sh_w_d;
      sh_dang_q <= sh_dang_d;
      nw_q      <= nw_d;
      dang_q    <= dang_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.valid      = valid_q;
  assign bus.nodeWeight = nw_q;
  assign bus.dangling   = dang_q;

endmodule

// File: tb/tb_node_weight_gen.sv
// Directed bench for node_weight_gen (N=4, WIDTH=16): latency, results, input
// masking, mid-run reset and back-to-back starts against hand-computed values.
module tb_node_weight_gen;

  localparam logic [15:0] ADJ_NOM  = 16'b0011_1011_0001_1100;
  localparam logic [63:0] W_NOM    = 64'h8000_FFFF_8000_5555;
  localparam logic [63:0] W_ONES   = 64'h4000_4000_4000_4000;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  node_weight_gen_if #(.N(4), .WIDTH(16)) bus ();

  node_weight_gen #(.N(4), .WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // one start pulse; optionally re-pokes adj/start at cycle 20 to show they are masked
  task automatic do_run(input logic [15:0] a, input logic [63:0] ew, input logic [3:0] ed,
                        input string tag, input bit poke);
    int          first_done;
    int          n_done;
    int          n_unstable;
    logic        b77;
    logic        b78;
    logic [63:0] held;
    held = bus.nodeWeight;
    first_done = 0;
    n_done = 0;
    n_unstable = 0;
    b77 = 1'b0;
    b78 = 1'b1;
    @(negedge clk);
    bus.adj   = a;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (poke && k == 20) begin
        bus.adj   = 16'hFFFF;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
      if (k < 77 && bus.nodeWeight !== held) n_unstable++;
      if (k == 77) b77 = bus.busy;
      if (k == 78) b78 = bus.busy;
    end
    check({tag, "_done_cycle"}, 64'(first_done), 64'd77);
    check({tag, "_done_count"}, 64'(n_done), 64'd1);
    check({tag, "_hold"}, 64'(n_unstable), 64'd0);
    check({tag, "_busy_done"}, 64'(b77), 64'd1);
    check({tag, "_busy_idle"}, 64'(b78), 64'd0);
    check({tag, "_weight"}, bus.nodeWeight, ew);
    check({tag, "_dangling"}, 64'(bus.dangling), 64'(ed));
    check({tag, "_valid"}, 64'(bus.valid), 64'd1);
  endtask

  initial begin
    int          first_done;
    int          second_done;
    int          n_done;
    int          n_unstable;
    logic        b78;
    logic [63:0] w77;

    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.adj   = '0;

    #23;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_weight", bus.nodeWeight, 64'd0);
    check("rst_dangling", 64'(bus.dangling), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    do_run(ADJ_NOM, W_NOM, 4'h0, "nominal", 1'b0);
    do_run(16'hFFFF, W_ONES, 4'h0, "all_ones", 1'b0);
    do_run(16'h0000, 64'd0, 4'hF, "all_zeros", 1'b0);
    do_run(ADJ_NOM, W_NOM, 4'h0, "masked", 1'b1);

    // reset in the middle of a run that follows a completed all-ones run
    do_run(16'hFFFF, W_ONES, 4'h0, "pre_rst", 1'b0);
    @(negedge clk);
    bus.adj   = ADJ_NOM;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_valid", 64'(bus.valid), 64'd0);
    check("midrst_weight", bus.nodeWeight, 64'd0);
    check("midrst_dangling", 64'(bus.dangling), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    do_run(ADJ_NOM, W_NOM, 4'h0, "post_rst", 1'b0);

    // back-to-back with start held high
    first_done  = 0;
    second_done = 0;
    n_done      = 0;
    n_unstable  = 0;
    b78         = 1'b0;
    w77         = '0;
    do_run(16'h0000, 64'd0, 4'hF, "b2b_prep", 1'b0);
    @(negedge clk);
    bus.adj   = ADJ_NOM;
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k == 1)       bus.adj = 16'h0000;
      else if (k == 78) bus.adj = 16'hFFFF;
      else if (k == 79) begin
        bus.adj   = 16'h0000;
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_done == 0)       first_done  = k;
        else if (second_done == 0) second_done = k;
      end
      if (k == 77) w77 = bus.nodeWeight;
      if (k == 78) b78 = bus.busy;
      if (k > 77 && k < 155 && bus.nodeWeight !== W_NOM) n_unstable++;
    end
    check("b2b_first_done", 64'(first_done), 64'd77);
    check("b2b_first_weight", w77, W_NOM);
    check("b2b_busy_reaccept", 64'(b78), 64'd1);
    check("b2b_hold", 64'(n_unstable), 64'd0);
    check("b2b_second_done", 64'(second_done), 64'd155);
    check("b2b_done_count", 64'(n_done), 64'd2);
    check("b2b_second_weight", bus.nodeWeight, W_ONES);
    check("b2b_dangling", 64'(bus.dangling), 64'd0);
    check("b2b_busy_end", 64'(bus.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
